// File: rtl/riscvbyp_hazard_ctrl.sv
// rtl/riscvbyp_hazard_ctrl.sv - hazard/bypass/stall sequencer for the 5-stage bypass RISC-V pipeline
// Shadows X/M/W destination info; drives bypass selects, stalls, bubbles and the mul/div handshake.
module riscvbyp_hazard_ctrl #(
  parameter int NREGS = 32,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_val_Dhl,
  input  logic          rs1_en_Dhl,
  input  logic [RW-1:0] rs1_Dhl,
  input  logic          rs2_en_Dhl,
  input  logic [RW-1:0] rs2_Dhl,
  input  logic          rf_wen_Dhl,
  input  logic [RW-1:0] rf_waddr_Dhl,
  input  logic          is_load_Dhl,
  input  logic          is_mem_Dhl,
  input  logic          is_muldiv_Dhl,
  input  logic          jump_Dhl,
  input  logic          brj_taken_Xhl,
  input  logic          dmemresp_val_Mhl,
  input  logic          muldivreq_rdy,
  input  logic          muldivresp_val,
  output logic [1:0]    rs1_byp_mux_sel_Dhl,
  output logic [1:0]    rs2_byp_mux_sel_Dhl,
  output logic          stall_Fhl,
  output logic          stall_Dhl,
  output logic          stall_Xhl,
  output logic          stall_Mhl,
  output logic          stall_Whl,
  output logic          muldivreq_val,
  output logic          muldivresp_rdy,
  output logic          rf_wen_Whl,
  output logic [RW-1:0] rf_waddr_Whl
);

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

  logic          r_val_X, r_wen_X, r_ld_X, r_mem_X, r_md_X;
  logic [RW-1:0] r_waddr_X;
  logic          r_val_M, r_wen_M, r_mem_M;
  logic [RW-1:0] r_waddr_M;
  logic          r_val_W, r_wen_W;
  logic [RW-1:0] r_waddr_W;
  md_state_t     r_md_state, w_md_next;

  // F squash on a D-resolved jump is applied by the datapath's own D-valid logic.
  logic w_unused;
  assign w_unused = jump_Dhl;

  // Gating valids with reset forces every output low during the reset cycle itself.
  logic w_val_X, w_val_M, w_val_W;
  assign w_val_X = r_val_X & ~reset;
  assign w_val_M = r_val_M & ~reset;
  assign w_val_W = r_val_W & ~reset;

  function automatic logic f_match(input logic en, input logic [RW-1:0] r,
                                   input logic v, input logic wen, input logic [RW-1:0] wa);
    return en && (r != '0) && v && wen && (wa == r);
  endfunction

  logic w_m1_X, w_m1_M, w_m1_W, w_m2_X, w_m2_M, w_m2_W;
  assign w_m1_X = f_match(rs1_en_Dhl, rs1_Dhl, w_val_X, r_wen_X, r_waddr_X);
  assign w_m1_M = f_match(rs1_en_Dhl, rs1_Dhl, w_val_M, r_wen_M, r_waddr_M);
  assign w_m1_W = f_match(rs1_en_Dhl, rs1_Dhl, w_val_W, r_wen_W, r_waddr_W);
  assign w_m2_X = f_match(rs2_en_Dhl, rs2_Dhl, w_val_X, r_wen_X, r_waddr_X);
  assign w_m2_M = f_match(rs2_en_Dhl, rs2_Dhl, w_val_M, r_wen_M, r_waddr_M);
  assign w_m2_W = f_match(rs2_en_Dhl, rs2_Dhl, w_val_W, r_wen_W, r_waddr_W);

  always_comb begin
    rs1_byp_mux_sel_Dhl = 2'd0;
    if (w_m1_X)      rs1_byp_mux_sel_Dhl = 2'd1;
    else if (w_m1_M) rs1_byp_mux_sel_Dhl = 2'd2;
    else if (w_m1_W) rs1_byp_mux_sel_Dhl = 2'd3;
    rs2_byp_mux_sel_Dhl = 2'd0;
    if (w_m2_X)      rs2_byp_mux_sel_Dhl = 2'd1;
    else if (w_m2_M) rs2_byp_mux_sel_Dhl = 2'd2;
    else if (w_m2_W) rs2_byp_mux_sel_Dhl = 2'd3;
  end

  logic w_load_use, w_mem_wait_M, w_md_busy, w_md_wait_X;
  assign w_load_use   = w_val_X & r_ld_X & (w_m1_X | w_m2_X);
  assign w_mem_wait_M = w_val_M & r_mem_M & ~dmemresp_val_Mhl;
  assign w_md_busy    = (r_md_state == MD_BUSY) & ~reset;
  assign w_md_wait_X  = w_val_X & r_md_X & ~(w_md_busy & muldivresp_val);

  assign stall_Whl = 1'b0;
  assign stall_Mhl = w_mem_wait_M;
  assign stall_Xhl = stall_Mhl | w_md_wait_X;
  assign stall_Dhl = stall_Xhl | (inst_val_Dhl & w_load_use);
  assign stall_Fhl = stall_Dhl;

  always_ff @(posedge clk) begin
    if (reset) r_md_state <= MD_IDLE;
    else       r_md_state <= w_md_next;
  end

  always_comb begin
    w_md_next = r_md_state;
    case (r_md_state)
      MD_IDLE: if (w_val_X & r_md_X & muldivreq_rdy) w_md_next = MD_BUSY;
      MD_BUSY: if (muldivresp_val & ~stall_Mhl)     w_md_next = MD_IDLE;
      default: w_md_next = MD_IDLE;
    endcase
  end

  always_comb begin
    muldivreq_val  = 1'b0;
    muldivresp_rdy = 1'b0;
    case (r_md_state)
      MD_IDLE: muldivreq_val  = w_val_X & r_md_X;
      MD_BUSY: muldivresp_rdy = ~stall_Mhl & ~reset;
      default: ;
    endcase
  end

  // A taken branch is only acted on when X can advance; it turns the D instruction into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_val_X <= 1'b0; r_wen_X <= 1'b0; r_ld_X <= 1'b0; r_mem_X <= 1'b0; r_md_X <= 1'b0;
      r_waddr_X <= '0;
      r_val_M <= 1'b0; r_wen_M <= 1'b0; r_mem_M <= 1'b0; r_waddr_M <= '0;
      r_val_W <= 1'b0; r_wen_W <= 1'b0; r_waddr_W <= '0;
    end else begin
      if (!stall_Xhl) begin
        r_val_X   <= inst_val_Dhl & ~stall_Dhl & ~brj_taken_Xhl;
        r_wen_X   <= rf_wen_Dhl;
        r_waddr_X <= rf_waddr_Dhl;
        r_ld_X    <= is_load_Dhl;
        r_mem_X   <= is_mem_Dhl;
        r_md_X    <= is_muldiv_Dhl;
      end
      if (!stall_Mhl) begin
        r_val_M   <= r_val_X & ~stall_Xhl;
        r_wen_M   <= r_wen_X;
        r_waddr_M <= r_waddr_X;
        r_mem_M   <= r_mem_X;
      end
      r_val_W   <= r_val_M & ~stall_Mhl;
      r_wen_W   <= r_wen_M;
      r_waddr_W <= r_waddr_M;
    end
  end

  assign rf_wen_Whl   = w_val_W & r_wen_W;
  assign rf_waddr_Whl = reset ? '0 : r_waddr_W;

endmodule

// File: tb/tb_riscvbyp_hazard_ctrl.sv
// tb/tb_riscvbyp_hazard_ctrl.sv - randomized scoreboard bench for riscvbyp_hazard_ctrl
// A driver predicts each cycle's outputs from an instruction-level pipeline model; a monitor compares.
module tb_riscvbyp_hazard_ctrl;

  localparam int RW = 5;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic inst_val_Dhl = 0, rs1_en_Dhl = 0, rs2_en_Dhl = 0, rf_wen_Dhl = 0;
  logic [RW-1:0] rs1_Dhl = '0, rs2_Dhl = '0, rf_waddr_Dhl = '0;
  logic is_load_Dhl = 0, is_mem_Dhl = 0, is_muldiv_Dhl = 0, jump_Dhl = 0, brj_taken_Xhl = 0;
  logic dmemresp_val_Mhl = 0, muldivreq_rdy = 0, muldivresp_val = 0;
  logic [1:0] rs1_byp_mux_sel_Dhl, rs2_byp_mux_sel_Dhl;
  logic stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl;
  logic muldivreq_val, muldivresp_rdy, rf_wen_Whl;
  logic [RW-1:0] rf_waddr_Whl;

  riscvbyp_hazard_ctrl #(.NREGS(32), .RW(RW)) dut (
    .clk(clk), .reset(reset),
    .inst_val_Dhl(inst_val_Dhl), .rs1_en_Dhl(rs1_en_Dhl), .rs1_Dhl(rs1_Dhl),
    .rs2_en_Dhl(rs2_en_Dhl), .rs2_Dhl(rs2_Dhl), .rf_wen_Dhl(rf_wen_Dhl),
    .rf_waddr_Dhl(rf_waddr_Dhl), .is_load_Dhl(is_load_Dhl), .is_mem_Dhl(is_mem_Dhl),
    .is_muldiv_Dhl(is_muldiv_Dhl), .jump_Dhl(jump_Dhl), .brj_taken_Xhl(brj_taken_Xhl),
    .dmemresp_val_Mhl(dmemresp_val_Mhl), .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_val(muldivresp_val),
    .rs1_byp_mux_sel_Dhl(rs1_byp_mux_sel_Dhl), .rs2_byp_mux_sel_Dhl(rs2_byp_mux_sel_Dhl),
    .stall_Fhl(stall_Fhl), .stall_Dhl(stall_Dhl), .stall_Xhl(stall_Xhl),
    .stall_Mhl(stall_Mhl), .stall_Whl(stall_Whl),
    .muldivreq_val(muldivreq_val), .muldivresp_rdy(muldivresp_rdy),
    .rf_wen_Whl(rf_wen_Whl), .rf_waddr_Whl(rf_waddr_Whl)
  );

  typedef struct packed {
    bit v, wen, ld, mem, md;
    bit [RW-1:0] rd;
  } instr_t;

  typedef struct packed {
    bit [1:0] s1, s2;
    bit sF, sD, sX, sM, sW, req, rrdy, wen, chk_wa;
    bit [RW-1:0] wa;
  } exp_t;

  instr_t pipe [3];    // 0 = X, 1 = M, 2 = W
  bit     md_busy;
  bit     rst_prev;
  exp_t   sb [$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;

  function automatic bit [1:0] m_sel(bit en, bit [RW-1:0] r);
    if (!en || r == 0) return 2'd0;
    for (int s = 0; s < 3; s++)
      if (pipe[s].v && pipe[s].wen && pipe[s].rd == r) return 2'(s + 1);
    return 2'd0;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    instr_t d, nx, nm, nw;
    bit lu, sM, sX, sD;
    e = '0;
    if (reset) begin
      e.chk_wa = 1;
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      md_busy = 0;
      rst_prev = 1;
    end else begin
      d = '{v: inst_val_Dhl, wen: rf_wen_Dhl, ld: is_load_Dhl, mem: is_mem_Dhl,
            md: is_muldiv_Dhl, rd: rf_waddr_Dhl};
      e.s1 = m_sel(rs1_en_Dhl, rs1_Dhl);
      e.s2 = m_sel(rs2_en_Dhl, rs2_Dhl);
      lu = pipe[0].v && pipe[0].ld && (e.s1 == 1 || e.s2 == 1);
      sM = pipe[1].v && pipe[1].mem && !dmemresp_val_Mhl;
      sX = sM || (pipe[0].v && pipe[0].md && !(md_busy && muldivresp_val));
      sD = sX || (inst_val_Dhl && lu);
      e.sM = sM; e.sX = sX; e.sD = sD; e.sF = sD; e.sW = 0;
      e.req  = !md_busy && pipe[0].v && pipe[0].md;
      e.rrdy = md_busy && !sM;
      e.wen  = pipe[2].v && pipe[2].wen;
      e.wa   = pipe[2].rd;
      e.chk_wa = e.wen || rst_prev;
      if (!md_busy) begin
        if (e.req && muldivreq_rdy) md_busy = 1;
      end else if (muldivresp_val && !sM) md_busy = 0;
      nw = pipe[1]; if (sM) nw.v = 0;
      if (sM) nm = pipe[1];
      else begin nm = pipe[0]; if (sX) nm.v = 0; end
      if (sX) nx = pipe[0];
      else begin nx = d; if (sD || brj_taken_Xhl) nx.v = 0; end
      pipe[0] = nx; pipe[1] = nm; pipe[2] = nw;
      rst_prev = 0;
    end
    sb.push_back(e);
  endtask

  task automatic randomize_inputs(int i);
    int kind;
    reset = (i < 3) || ($urandom_range(0, 79) == 0);
    kind = $urandom_range(0, 9);
    inst_val_Dhl  = $urandom_range(0, 99) < 85;
    rs1_en_Dhl    = $urandom_range(0, 9) < 8;
    rs2_en_Dhl    = $urandom_range(0, 9) < 6;
    rs1_Dhl       = RW'($urandom_range(0, 3));
    rs2_Dhl       = RW'($urandom_range(0, 3));
    rf_waddr_Dhl  = RW'($urandom_range(0, 3));
    is_load_Dhl   = (kind <= 2);
    is_mem_Dhl    = (kind <= 3);
    is_muldiv_Dhl = (kind == 4);
    rf_wen_Dhl    = (kind != 3) && (kind != 9);
    jump_Dhl      = $urandom_range(0, 9) == 0;
    brj_taken_Xhl = $urandom_range(0, 9) == 0;
    dmemresp_val_Mhl = $urandom_range(0, 99) < 70;
    muldivreq_rdy    = $urandom_range(0, 99) < 60;
    muldivresp_val   = $urandom_range(0, 99) < 25;
  endtask

  initial begin
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    md_busy = 0;
    rst_prev = 0;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      randomize_inputs(i);
      model_step();
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cyc++;
      chk("rs1_sel", int'(rs1_byp_mux_sel_Dhl), int'(e.s1));
      chk("rs2_sel", int'(rs2_byp_mux_sel_Dhl), int'(e.s2));
      chk("stall_F", int'(stall_Fhl), int'(e.sF));
      chk("stall_D", int'(stall_Dhl), int'(e.sD));
      chk("stall_X", int'(stall_Xhl), int'(e.sX));
      chk("stall_M", int'(stall_Mhl), int'(e.sM));
      chk("stall_W", int'(stall_Whl), int'(e.sW));
      chk("muldivreq_val", int'(muldivreq_val), int'(e.req));
      chk("muldivresp_rdy", int'(muldivresp_rdy), int'(e.rrdy));
      chk("rf_wen_W", int'(rf_wen_Whl), int'(e.wen));
      if (e.chk_wa) chk("rf_waddr_W", int'(rf_waddr_Whl), int'(e.wa));
    end
  end

endmodule
